// File: rtl/kernel_bc_start_arbiter_pkg.sv
// Shared definitions for the kernel_bc start arbiter: state encoding and parameter defaults.
package kernel_bc_start_arbiter_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ID_WIDTH       = 2;
  localparam int DEF_TAG_DEPTH      = 4;
  localparam int DEF_TAG_ADDR_WIDTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    START = 1'b1
  } arbState_e;

endpackage

// File: rtl/kernel_bc_start_arbiter_if.sv
// Handshake bundle between the start FIFOs, the shared HLS task and the arbiter.
interface kernel_bc_start_arbiter_if
  import kernel_bc_start_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int TAG_ADDR_WIDTH = DEF_TAG_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]      req_empty_n;
  logic [NUM_REQ-1:0]      req_read;
  logic                    task_ap_start;
  logic                    task_ap_ready;
  logic                    task_ap_done;
  logic                    done_valid;
  logic [ID_WIDTH-1:0]     done_id;
  logic [NUM_REQ-1:0]      done_onehot;
  logic [TAG_ADDR_WIDTH:0] outstanding;
  logic                    busy;
  logic                    protocol_err;

  modport master (
    input  req_empty_n, task_ap_ready, task_ap_done,
    output req_read, task_ap_start, done_valid, done_id, done_onehot,
           outstanding, busy, protocol_err
  );

  modport slave (
    output req_empty_n, task_ap_ready, task_ap_done,
    input  req_read, task_ap_start, done_valid, done_id, done_onehot,
           outstanding, busy, protocol_err
  );

endinterface

// File: rtl/kernel_bc_start_arb_tagq.sv
// In-order tag queue holding the requester ID of every launched task, shift-register style.
module kernel_bc_start_arb_tagq
  import kernel_bc_start_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEF_ID_WIDTH,
  parameter int DEPTH      = DEF_TAG_DEPTH,
  parameter int ADDR_WIDTH = DEF_TAG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      din_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDR_WIDTH:0] mOutPtr_q;
  logic                doPush;
  logic                doPop;

  // mOutPtr sits at all-ones when empty and points at the oldest entry otherwise.
  assign empty_o = (mOutPtr_q == '1);
  assign full_o  = (mOutPtr_q == (ADDR_WIDTH+1)'(DEPTH-1));
  assign count_o = mOutPtr_q + 1'b1;
  assign dout_o  = mem_q[mOutPtr_q[ADDR_WIDTH-1:0]];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mOutPtr_q <= '1;
    end else if (doPush && !doPop) begin
      mOutPtr_q <= mOutPtr_q + 1'b1;
    end else if (doPop && !doPush) begin
      mOutPtr_q <= mOutPtr_q - 1'b1;
    end
  end

endmodule

// File: rtl/kernel_bc_start_arbiter.sv
// Round-robin start scheduler sharing one HLS dataflow task between NUM_REQ start FIFOs,
// routing each ap_done back to the producer that launched it.
module kernel_bc_start_arbiter
  import kernel_bc_start_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int TAG_DEPTH      = DEF_TAG_DEPTH,
  parameter int TAG_ADDR_WIDTH = DEF_TAG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  kernel_bc_start_arbiter_if.master bus
);

  arbState_e              state_q, state_d;
  logic [ID_WIDTH-1:0]    rrPtr_q, rrPtr_d;
  logic [ID_WIDTH-1:0]    grantId_q, grantId_d;
  logic                   doneValid_q;
  logic [ID_WIDTH-1:0]    doneId_q;
  logic [NUM_REQ-1:0]     doneOnehot_q;
  logic                   protoErr_q;

  logic [ID_WIDTH:0]      pick;
  logic                   pickValid;
  logic [ID_WIDTH-1:0]    pickId;
  logic [NUM_REQ-1:0]     reqRead;
  logic                   tagPush;
  logic                   tagPop;
  logic                   tagFull;
  logic                   tagEmpty;
  logic [ID_WIDTH-1:0]    tagHead;
  logic [TAG_ADDR_WIDTH:0] tagCount;

  // Circular search from ptr; descending scan so the lowest offset wins. Returns {found, id}.
  function automatic logic [ID_WIDTH:0] rrPick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH:0] res;
    int                idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) res = {1'b1, ID_WIDTH'(idx)};
    end
    return res;
  endfunction

  assign pick      = rrPick(bus.req_empty_n, rrPtr_q);
  assign pickValid = pick[ID_WIDTH];
  assign pickId    = pick[ID_WIDTH-1:0];
  assign tagPop    = bus.task_ap_done && !tagEmpty;

  kernel_bc_start_arb_tagq #(
    .WIDTH      (ID_WIDTH),
    .DEPTH      (TAG_DEPTH),
    .ADDR_WIDTH (TAG_ADDR_WIDTH)
  ) u_tagq (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tagPush),
    .pop_i   (tagPop),
    .din_i   (pickId),
    .dout_o  (tagHead),
    .full_o  (tagFull),
    .empty_o (tagEmpty),
    .count_o (tagCount)
  );

  // Full is judged on the registered count, so a same-cycle ap_done never frees a slot early.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grantId_d = grantId_q;
    reqRead   = '0;
    tagPush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid && !tagFull) begin
          reqRead   = NUM_REQ'(1) << pickId;
          tagPush   = 1'b1;
          grantId_d = pickId;
          state_d   = START;
        end
      end
      START: begin
        if (bus.task_ap_ready) begin
          rrPtr_d = (grantId_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantId_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      grantId_q    <= '0;
      doneValid_q  <= 1'b0;
      doneId_q     <= '0;
      doneOnehot_q <= '0;
      protoErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      grantId_q   <= grantId_d;
      doneValid_q <= tagPop;
      if (tagPop) begin
        doneId_q     <= tagHead;
        doneOnehot_q <= NUM_REQ'(1) << tagHead;
      end else begin
        doneOnehot_q <= '0;
      end
      if (bus.task_ap_done && tagEmpty) protoErr_q <= 1'b1;
    end
  end

  assign bus.req_read      = reqRead;
  assign bus.task_ap_start = (state_q == START);
  assign bus.done_valid    = doneValid_q;
  assign bus.done_id       = doneId_q;
  assign bus.done_onehot   = doneOnehot_q;
  assign bus.outstanding   = tagCount;
  assign bus.busy          = (state_q != IDLE) || (tagCount != '0);
  assign bus.protocol_err  = protoErr_q;

endmodule

// File: tb/tb_kernel_bc_start_arbiter.sv
// Directed self-checking bench for kernel_bc_start_arbiter with hand-computed expectations.
module tb_kernel_bc_start_arbiter;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  kernel_bc_start_arbiter_if #(.NUM_REQ(4), .ID_WIDTH(2), .TAG_ADDR_WIDTH(2)) bus ();

  kernel_bc_start_arbiter #(
    .NUM_REQ        (4),
    .ID_WIDTH       (2),
    .TAG_DEPTH      (4),
    .TAG_ADDR_WIDTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqVec, input logic ready, input logic done);
    bus.req_empty_n   = reqVec;
    bus.task_ap_ready = ready;
    bus.task_ap_done  = done;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int nPush;
    int nPop;
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);

    // Reset state
    doReset();
    #1;
    checkOutput("rst_req_read", 32'(bus.req_read), 32'h0);
    checkOutput("rst_ap_start", 32'(bus.task_ap_start), 32'h0);
    checkOutput("rst_done_valid", 32'(bus.done_valid), 32'h0);
    checkOutput("rst_done_id", 32'(bus.done_id), 32'h0);
    checkOutput("rst_done_onehot", 32'(bus.done_onehot), 32'h0);
    checkOutput("rst_outstanding", 32'(bus.outstanding), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_protocol_err", 32'(bus.protocol_err), 32'h0);

    // Single requester 2
    $display("[TB] single requester");
    applyStimulus(4'b0100, 1'b0, 1'b0); #1;
    checkOutput("single_grant_read", 32'(bus.req_read), 32'h4);
    checkOutput("single_grant_start", 32'(bus.task_ap_start), 32'h0);
    tick(); applyStimulus(4'b0000, 1'b0, 1'b0); #1;
    checkOutput("single_s1_read", 32'(bus.req_read), 32'h0);
    checkOutput("single_s1_start", 32'(bus.task_ap_start), 32'h1);
    checkOutput("single_s1_outstanding", 32'(bus.outstanding), 32'h1);
    checkOutput("single_s1_busy", 32'(bus.busy), 32'h1);
    tick(); applyStimulus(4'b0000, 1'b1, 1'b0); #1;
    checkOutput("single_s2_start", 32'(bus.task_ap_start), 32'h1);
    checkOutput("single_s2_read", 32'(bus.req_read), 32'h0);
    tick(); applyStimulus(4'b0000, 1'b0, 1'b0); #1;
    checkOutput("single_after_ready_start", 32'(bus.task_ap_start), 32'h0);
    checkOutput("single_after_ready_busy", 32'(bus.busy), 32'h1);
    repeat (4) tick();
    applyStimulus(4'b0000, 1'b0, 1'b1); #1;
    checkOutput("single_done_cycle_valid", 32'(bus.done_valid), 32'h0);
    tick(); applyStimulus(4'b0000, 1'b0, 1'b0); #1;
    checkOutput("single_done_valid", 32'(bus.done_valid), 32'h1);
    checkOutput("single_done_id", 32'(bus.done_id), 32'h2);
    checkOutput("single_done_onehot", 32'(bus.done_onehot), 32'h4);
    checkOutput("single_done_outstanding", 32'(bus.outstanding), 32'h0);
    tick(); #1;
    checkOutput("single_done_drop", 32'(bus.done_valid), 32'h0);
    checkOutput("single_done_onehot_drop", 32'(bus.done_onehot), 32'h0);
    checkOutput("single_idle_busy", 32'(bus.busy), 32'h0);

    // Constant demand: grants every 2 cycles in order 0,1,2,3,0,1; done 3 cycles after ready
    $display("[TB] round robin");
    doReset();
    for (int c = 0; c <= 16; c++) begin
      applyStimulus((c < 12) ? 4'b1111 : 4'b0000, 1'b1,
                    (c >= 4 && c <= 14 && (c % 2) == 0));
      #1;
      nPush = 0;
      nPop  = 0;
      for (int k = 0; k < 6; k++) begin
        if (2*k + 1 <= c) nPush++;
        if (2*k + 5 <= c) nPop++;
      end
      checkOutput($sformatf("rr_read_c%0d", c), 32'(bus.req_read),
                  (c < 12 && (c % 2) == 0) ? (32'h1 << ((c / 2) % 4)) : 32'h0);
      checkOutput($sformatf("rr_start_c%0d", c), 32'(bus.task_ap_start),
                  32'((c < 12 && (c % 2) == 1) ? 1 : 0));
      checkOutput($sformatf("rr_outstanding_c%0d", c), 32'(bus.outstanding), 32'(nPush - nPop));
      checkOutput($sformatf("rr_done_valid_c%0d", c), 32'(bus.done_valid),
                  32'((c >= 5 && c <= 15 && (c % 2) == 1) ? 1 : 0));
      if (c >= 5 && c <= 15 && (c % 2) == 1)
        checkOutput($sformatf("rr_done_id_c%0d", c), 32'(bus.done_id), 32'(((c - 5) / 2) % 4));
      tick();
    end

    // Full tag queue blocks further grants
    $display("[TB] full queue");
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0); #1;
      checkOutput($sformatf("full_read_c%0d", c), 32'(bus.req_read),
                  ((c % 2) == 0) ? (32'h1 << (c / 2)) : 32'h0);
      tick();
    end
    applyStimulus(4'b1111, 1'b1, 1'b0); #1;
    checkOutput("full_c8_read", 32'(bus.req_read), 32'h0);
    checkOutput("full_c8_outstanding", 32'(bus.outstanding), 32'h4);
    checkOutput("full_c8_busy", 32'(bus.busy), 32'h1);
    tick(); #1;
    checkOutput("full_c9_read", 32'(bus.req_read), 32'h0);
    tick(); applyStimulus(4'b1111, 1'b1, 1'b1); #1;
    checkOutput("full_pop_cycle_read", 32'(bus.req_read), 32'h0);
    tick(); applyStimulus(4'b1111, 1'b1, 1'b0); #1;
    checkOutput("full_done_valid", 32'(bus.done_valid), 32'h1);
    checkOutput("full_done_id", 32'(bus.done_id), 32'h0);
    checkOutput("full_outstanding_after", 32'(bus.outstanding), 32'h3);
    checkOutput("full_next_grant", 32'(bus.req_read), 32'h1);

    // Grant and done in the same cycle with two outstanding
    $display("[TB] simultaneous push and pop");
    doReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(4'b1111, 1'b1, 1'b1); #1;
    checkOutput("simul_grant_read", 32'(bus.req_read), 32'h4);
    checkOutput("simul_outstanding_before", 32'(bus.outstanding), 32'h2);
    tick(); applyStimulus(4'b0000, 1'b1, 1'b0); #1;
    checkOutput("simul_outstanding_after", 32'(bus.outstanding), 32'h2);
    checkOutput("simul_done_valid", 32'(bus.done_valid), 32'h1);
    checkOutput("simul_done_id", 32'(bus.done_id), 32'h0);

    // ap_done with nothing outstanding
    $display("[TB] protocol error");
    doReset();
    applyStimulus(4'b0000, 1'b0, 1'b1); #1;
    checkOutput("perr_before", 32'(bus.protocol_err), 32'h0);
    tick(); applyStimulus(4'b0000, 1'b0, 1'b0); #1;
    checkOutput("perr_no_done_valid", 32'(bus.done_valid), 32'h0);
    checkOutput("perr_set", 32'(bus.protocol_err), 32'h1);
    checkOutput("perr_outstanding", 32'(bus.outstanding), 32'h0);
    repeat (3) tick();
    checkOutput("perr_sticky", 32'(bus.protocol_err), 32'h1);

    // Reset while in START with three tags outstanding
    $display("[TB] reset mid-operation");
    doReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1111, (c % 2) == 1, 1'b0); #1;
      if (c == 4) checkOutput("midrst_third_grant", 32'(bus.req_read), 32'h4);
      tick();
    end
    applyStimulus(4'b0000, 1'b0, 1'b0); #1;
    checkOutput("midrst_in_start", 32'(bus.task_ap_start), 32'h1);
    checkOutput("midrst_outstanding3", 32'(bus.outstanding), 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_start_cleared", 32'(bus.task_ap_start), 32'h0);
    checkOutput("midrst_outstanding0", 32'(bus.outstanding), 32'h0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'h0);
    checkOutput("midrst_perr_clear", 32'(bus.protocol_err), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick(); applyStimulus(4'b0000, 1'b0, 1'b0); #1;
    checkOutput("midrst_late_done_valid", 32'(bus.done_valid), 32'h0);
    checkOutput("midrst_late_perr", 32'(bus.protocol_err), 32'h1);
    applyStimulus(4'b1111, 1'b0, 1'b0); #1;
    checkOutput("midrst_rr_ptr_zero", 32'(bus.req_read), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
